// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: key FSM state type and default timing constants
// derived from the 50 MHz board clock.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    HELD     = 2'd2
  } key_state_t;

  localparam int CLK_HZ        = 50000000;
  localparam int DEBOUNCE_20MS = CLK_HZ / 50;
  localparam int LONG_1S       = CLK_HZ;
  localparam int REPEAT_200MS  = CLK_HZ / 5;

endpackage

// File: rtl/key_conditioner_if.sv
// Conditioned key event bundle; the conditioner drives it, the stopwatch control reads it.
interface key_conditioner_if;

  logic key_level;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;
  logic toggle_state;

  modport master (
    output key_level,
    output press_pulse,
    output release_pulse,
    output long_pulse,
    output toggle_state
  );

  modport slave (
    input key_level,
    input press_pulse,
    input release_pulse,
    input long_pulse,
    input toggle_state
  );

endinterface

// File: rtl/sync_2ff.sv
// Reusable two-flop synchroniser for asynchronous board inputs, with a
// selectable reset value so idle-high pins come out of reset inactive.
module sync_2ff #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_1_time,
  input  logic d,
  output logic q
);

  logic s1_r;
  logic s2_r;

  // Two-stage metastability filter
  always_ff @(posedge clk or negedge reset_1_time) begin
    if (!reset_1_time) begin
      s1_r <= RESET_VAL;
      s2_r <= RESET_VAL;
    end else begin
      s1_r <= d;
      s2_r <= s1_r;
    end
  end

  assign q = s2_r;

endmodule

// File: rtl/key_conditioner.sv
// Per-key front end: synchronise, debounce and turn KEY into level/press/release/
// long/toggle events. Define KEY_REPEAT_EN to add auto-repeat press pulses while held.
module key_conditioner
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter int LONG_CYCLES     = LONG_1S,
`ifdef KEY_REPEAT_EN
  parameter int REPEAT_CYCLES   = REPEAT_200MS,
`endif
  parameter int CNT_W           = 32
) (
  input  logic               clk,
  input  logic               reset_1_time,
  input  logic               key_n,
  key_conditioner_if.master  evt
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic             s2_s;
  logic             stable_r;
  logic             key_level_r;
  logic [CNT_W-1:0] dcnt_r;
  logic             accept_s;
  logic             press_acc_s;
  logic             rel_acc_s;

  key_state_t       state_r;
  key_state_t       state_nxt_s;
  logic [CNT_W-1:0] hcnt_r;
  logic [CNT_W-1:0] hcnt_nxt_s;
`ifdef KEY_REPEAT_EN
  logic [CNT_W-1:0] rcnt_r;
  logic [CNT_W-1:0] rcnt_nxt_s;
`endif

  logic press_nxt_s, release_nxt_s, long_nxt_s, toggle_nxt_s;
  logic press_r, release_r, long_r, toggle_r;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk          (clk),
    .reset_1_time (reset_1_time),
    .d            (key_n),
    .q            (s2_s)
  );

  // Acceptance strobe: the level has differed from stable for the full window
  always_comb begin
    accept_s = 1'b0;
    if ((s2_s != stable_r) && (dcnt_r == DEB_LAST)) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    press_acc_s = accept_s & ~s2_s;
    rel_acc_s   = accept_s &  s2_s;
  end

  // Stable-time counter; key_level is updated on the accepting edge itself
  always_ff @(posedge clk or negedge reset_1_time) begin
    if (!reset_1_time) begin
      stable_r    <= 1'b1;
      key_level_r <= 1'b0;
      dcnt_r      <= '0;
    end else if (s2_s == stable_r) begin
      dcnt_r <= '0;
    end else if (dcnt_r == DEB_LAST) begin
      stable_r    <= s2_s;
      key_level_r <= ~s2_s;
      dcnt_r      <= '0;
    end else begin
      dcnt_r <= dcnt_r + CNT_W'(1);
    end
  end

  // FSM state and hold/repeat counters
  always_ff @(posedge clk or negedge reset_1_time) begin
    if (!reset_1_time) begin
      state_r <= RELEASED;
      hcnt_r  <= '0;
`ifdef KEY_REPEAT_EN
      rcnt_r  <= '0;
`endif
    end else begin
      state_r <= state_nxt_s;
      hcnt_r  <= hcnt_nxt_s;
`ifdef KEY_REPEAT_EN
      rcnt_r  <= rcnt_nxt_s;
`endif
    end
  end

  // Next state; an accepted release overrides everything else
  always_comb begin
    state_nxt_s = state_r;
    hcnt_nxt_s  = hcnt_r;
`ifdef KEY_REPEAT_EN
    rcnt_nxt_s  = rcnt_r;
`endif
    if (rel_acc_s) begin
      state_nxt_s = RELEASED;
      hcnt_nxt_s  = '0;
`ifdef KEY_REPEAT_EN
      rcnt_nxt_s  = '0;
`endif
    end else begin
      case (state_r)
        RELEASED: begin
          if (press_acc_s) begin
            state_nxt_s = PRESSED;
            hcnt_nxt_s  = '0;
          end else begin
            state_nxt_s = RELEASED;
          end
        end
        PRESSED: begin
          if (hcnt_r == LONG_LAST) begin
            state_nxt_s = HELD;
`ifdef KEY_REPEAT_EN
            rcnt_nxt_s  = '0;
`endif
          end else begin
            hcnt_nxt_s = hcnt_r + CNT_W'(1);
          end
        end
        HELD: begin
`ifdef KEY_REPEAT_EN
          if (rcnt_r == REP_LAST) begin
            rcnt_nxt_s = '0;
          end else begin
            rcnt_nxt_s = rcnt_r + CNT_W'(1);
          end
`else
          state_nxt_s = HELD;
`endif
        end
        default: state_nxt_s = RELEASED;
      endcase
    end
  end

  // Pulse decode, registered below so pulses line up with the state change
  always_comb begin
    press_nxt_s   = 1'b0;
    release_nxt_s = 1'b0;
    long_nxt_s    = 1'b0;
    toggle_nxt_s  = toggle_r;
    if (rel_acc_s) begin
      release_nxt_s = 1'b1;
    end else begin
      case (state_r)
        RELEASED: begin
          if (press_acc_s) begin
            press_nxt_s  = 1'b1;
            toggle_nxt_s = ~toggle_r;
          end else begin
            press_nxt_s = 1'b0;
          end
        end
        PRESSED: begin
          if (hcnt_r == LONG_LAST) begin
            long_nxt_s = 1'b1;
          end else begin
            long_nxt_s = 1'b0;
          end
        end
        HELD: begin
`ifdef KEY_REPEAT_EN
          if (rcnt_r == REP_LAST) begin
            press_nxt_s = 1'b1;
          end else begin
            press_nxt_s = 1'b0;
          end
`else
          press_nxt_s = 1'b0;
`endif
        end
        default: press_nxt_s = 1'b0;
      endcase
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge reset_1_time) begin
    if (!reset_1_time) begin
      press_r   <= 1'b0;
      release_r <= 1'b0;
      long_r    <= 1'b0;
      toggle_r  <= 1'b0;
    end else begin
      press_r   <= press_nxt_s;
      release_r <= release_nxt_s;
      long_r    <= long_nxt_s;
      toggle_r  <= toggle_nxt_s;
    end
  end

  assign evt.key_level     = key_level_r;
  assign evt.press_pulse   = press_r;
  assign evt.release_pulse = release_r;
  assign evt.long_pulse    = long_r;
  assign evt.toggle_state  = toggle_r;

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: directed scenarios plus random key
// activity, all compared cycle by cycle against an event-level reference model.
module tb_key_conditioner;

  localparam int DEB = 4;
  localparam int LNG = 20;
  localparam int REP = 8;

  logic clk = 1'b0;
  logic reset_1_time = 1'b0;
  logic key_n = 1'b1;

  int errors = 0;
  int checks = 0;

  key_conditioner_if evt ();

  key_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LNG),
`ifdef KEY_REPEAT_EN
    .REPEAT_CYCLES   (REP),
`endif
    .CNT_W           (32)
  ) dut (
    .clk          (clk),
    .reset_1_time (reset_1_time),
    .key_n        (key_n),
    .evt          (evt)
  );

  always #5 clk = ~clk;

  // Reference model: pin history, run length of disagreement, press age
  bit m_s1, m_s2, m_stable, m_pressed, m_toggle;
  bit e_press, e_rel, e_long;
  int m_run, m_age;

  task automatic model_reset();
    m_s1 = 1'b1; m_s2 = 1'b1; m_stable = 1'b1;
    m_pressed = 1'b0; m_toggle = 1'b0;
    e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
    m_run = 0; m_age = 0;
  endtask

  function automatic logic [4:0] obs();
    return {evt.key_level, evt.press_pulse, evt.release_pulse, evt.long_pulse, evt.toggle_state};
  endfunction

  function automatic logic [4:0] expv();
    return {~m_stable, e_press, e_rel, e_long, m_toggle};
  endfunction

  // Drive one pin value for one clock and advance the model over that edge
  task automatic step(input bit kn);
    bit seen;
    key_n = kn;
    @(posedge clk);
    seen = m_s2;
    m_s2 = m_s1;
    m_s1 = kn;
    e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
    if (seen == m_stable) begin
      m_run = 0;
    end else begin
      m_run++;
      if (m_run == DEB) begin
        m_stable = seen;
        m_run = 0;
        if (seen) begin
          e_rel = 1'b1;
          m_pressed = 1'b0;
        end else begin
          e_press = 1'b1;
          m_toggle = ~m_toggle;
          m_pressed = 1'b1;
          m_age = 0;
        end
      end
    end
    if (m_pressed && !e_press) begin
      m_age++;
      if (m_age == LNG) e_long = 1'b1;
`ifdef KEY_REPEAT_EN
      if (m_age > LNG && ((m_age - LNG) % REP) == 0) e_press = 1'b1;
`endif
    end
    #1;
  endtask

  task automatic test_reset();
    int rise;
    rise = -1;
    reset_1_time = 1'b0;
    key_n = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (obs() !== 5'b00000) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %b expected 00000", i, obs());
      end
    end
    reset_1_time = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step(1'b0);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL reset_press edge %0d: got %b expected %b", i, obs(), expv());
      end
      if (evt.key_level && rise < 0) rise = i;
    end
    checks++;
    if (rise !== 6) begin
      errors++;
      $display("FAIL reset_rise_edge: got %0d expected 6", rise);
    end
    checks++;
    if (evt.toggle_state !== 1'b1) begin
      errors++;
      $display("FAIL reset_toggle: got %b expected 1", evt.toggle_state);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b1);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL reset_release cycle %0d: got %b expected %b", i, obs(), expv());
      end
    end
  endtask

  task automatic test_bounce();
    bit pat [17] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                     1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    bit tog0;
    int activity;
    tog0 = evt.toggle_state;
    activity = 0;
    for (int i = 0; i < 17; i++) begin
      step(pat[i]);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL bounce cycle %0d: got %b expected %b", i, obs(), expv());
      end
      if (evt.key_level || evt.press_pulse || evt.toggle_state != tog0) activity++;
    end
    checks++;
    if (activity !== 0) begin
      errors++;
      $display("FAIL bounce_quiet: got %0d active cycles expected 0", activity);
    end
  endtask

  task automatic test_clean();
    int rise, fall, presses, releases, longs;
    rise = -1; fall = -1; presses = 0; releases = 0; longs = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1'b0);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL clean_press edge %0d: got %b expected %b", i, obs(), expv());
      end
      if (evt.key_level && rise < 0) rise = i;
      presses += int'(evt.press_pulse);
      longs += int'(evt.long_pulse);
    end
    for (int i = 1; i <= 12; i++) begin
      step(1'b1);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL clean_release edge %0d: got %b expected %b", i, obs(), expv());
      end
      if (!evt.key_level && fall < 0) fall = i;
      releases += int'(evt.release_pulse);
      longs += int'(evt.long_pulse);
    end
    checks++;
    if (rise !== 6 || fall !== 6) begin
      errors++;
      $display("FAIL clean_latency: got rise %0d fall %0d expected 6 and 6", rise, fall);
    end
    checks++;
    if (presses !== 1 || releases !== 1 || longs !== 0) begin
      errors++;
      $display("FAIL clean_counts: got p%0d r%0d l%0d expected p1 r1 l0", presses, releases, longs);
    end
  endtask

  task automatic test_long();
    int presses, longs, long_at, rel_at, exp_presses;
    bit tog0;
    presses = 0; longs = 0; long_at = -1; rel_at = -1;
    tog0 = evt.toggle_state;
`ifdef KEY_REPEAT_EN
    exp_presses = 5;
`else
    exp_presses = 1;
`endif
    for (int i = 1; i <= 72; i++) begin
      step(i <= 60 ? 1'b0 : 1'b1);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL long edge %0d: got %b expected %b", i, obs(), expv());
      end
      presses += int'(evt.press_pulse);
      longs += int'(evt.long_pulse);
      if (evt.long_pulse) long_at = i;
      if (evt.release_pulse) rel_at = i;
    end
    checks++;
    if (longs !== 1 || long_at !== 26) begin
      errors++;
      $display("FAIL long_pulse: got %0d pulses at edge %0d expected 1 at 26", longs, long_at);
    end
    checks++;
    if (presses !== exp_presses || rel_at !== 66) begin
      errors++;
      $display("FAIL long_press_count: got p%0d rel@%0d expected p%0d rel@66", presses, rel_at, exp_presses);
    end
    checks++;
    if (evt.toggle_state === tog0) begin
      errors++;
      $display("FAIL long_toggle: got %b expected %b", evt.toggle_state, ~tog0);
    end
  endtask

  task automatic test_async_reset();
    int presses;
    presses = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL areset_pre cycle %0d: got %b expected %b", i, obs(), expv());
      end
    end
    #2 reset_1_time = 1'b0;
    #1;
    checks++;
    if (obs() !== 5'b00000) begin
      errors++;
      $display("FAIL areset_immediate: got %b expected 00000", obs());
    end
    model_reset();
    @(posedge clk); #1;
    reset_1_time = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step(1'b0);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL areset_repress edge %0d: got %b expected %b", i, obs(), expv());
      end
      presses += int'(evt.press_pulse);
    end
    checks++;
    if (presses !== 1 || evt.toggle_state !== 1'b1) begin
      errors++;
      $display("FAIL areset_fresh_press: got p%0d t%b expected p1 t1", presses, evt.toggle_state);
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b1);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL areset_release cycle %0d: got %b expected %b", i, obs(), expv());
      end
    end
  endtask

  task automatic test_random();
    bit lvl;
    int len;
    lvl = 1'b0;
    for (int s = 0; s < 80; s++) begin
      len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(25, 40)) : int'($urandom_range(1, 8));
      for (int i = 0; i < len; i++) begin
        step(lvl);
        checks++;
        if (obs() !== expv()) begin
          errors++;
          $display("FAIL random seg %0d cycle %0d: got %b expected %b", s, i, obs(), expv());
        end
      end
      lvl = ~lvl;
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_clean();
    test_long();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Per-key front end for the stopwatch panel: one instance per push-button, directly upstream of the stopwatch control logic.
- Synchronises the raw active-low KEY pin into clk and debounces it by stable-time counting.
- Emits a clean pressed level, single-cycle press/release pulses, a long-press pulse and a press-toggled state bit. The stopwatch consumes these instead of edge-triggering on raw key signals.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required to accept a level change (20 ms at 50 MHz).
- LONG_CYCLES, 50000000: cycles key_level must stay high before long_pulse fires (1 s).
- REPEAT_CYCLES, 10000000: auto-repeat period while held (200 ms). Used only with KEY_REPEAT_EN.
- CNT_W, 32: width of all internal counters; must hold max(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES).

Ports:
- clk  in  1  50 MHz system clock; all state updates on rising edge.
- reset_1_time  in  1  asynchronous, active-low reset.
- key_n  in  1  raw KEY pin, asynchronous, 0 = pressed.
- key_level  out  1  debounced level, 1 = pressed.
- press_pulse  out  1  one-cycle pulse on accepted press (and on auto-repeat if enabled).
- release_pulse  out  1  one-cycle pulse on accepted release.
- long_pulse  out  1  one-cycle pulse when the press has lasted LONG_CYCLES.
- toggle_state  out  1  flips on each initial press (not on repeats).

Behaviour:
- Reset (reset_1_time=0, asynchronous assert, synchronous deassert from the clk edge):
  - sync flops = 1; stable = 1 (released).
  - All counters = 0; FSM = RELEASED.
  - key_level = press_pulse = release_pulse = long_pulse = toggle_state = 0.
- Synchroniser: two flops, s1 <= key_n, s2 <= s1. Only s2 is used downstream.
- Debounce counter dcnt:
  - If s2 == stable: dcnt <= 0.
  - Else if dcnt == DEBOUNCE_CYCLES-1: stable <= s2, dcnt <= 0 (accept).
  - Else: dcnt <= dcnt+1.
- Latency: key_level changes on the (DEBOUNCE_CYCLES+2)th rising edge, counting the edge that first samples the new key_n value as edge 1.
- Glitch rule: any bounce back to the stable value clears dcnt, so the stable time restarts.
- key_level = ~stable, registered.
- FSM states: RELEASED, PRESSED, HELD.
  - RELEASED: on an accepted press, go to PRESSED. Assert press_pulse for 1 cycle and toggle toggle_state, both on the same edge that key_level rises. Clear hcnt.
  - PRESSED: hcnt increments each cycle. When hcnt == LONG_CYCLES-1, assert long_pulse for 1 cycle, go to HELD, clear rcnt.
  - HELD: wait (see Optional Feature).
  - Any state: an accepted release goes to RELEASED, asserts release_pulse for 1 cycle and clears hcnt/rcnt. Release takes priority over long_pulse or repeat on the same edge.
- Pulses are exactly one cycle wide and never overlap, except that press_pulse coinciding with toggle_state changing is intended.
- Counters saturate, never wrap: hcnt stops at LONG_CYCLES-1 because the FSM has left PRESSED.
- Reset mid-press: all outputs return to 0 immediately. A key still held after reset deasserts is re-debounced and produces a fresh press_pulse.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined: in HELD, rcnt increments each cycle. At rcnt == REPEAT_CYCLES-1, press_pulse is asserted for 1 cycle and rcnt is cleared. Repeat pulses do not toggle toggle_state. The first repeat comes REPEAT_CYCLES cycles after long_pulse.
- Undefined: HELD is a pure wait-for-release state; rcnt and REPEAT_CYCLES logic are absent; press_pulse fires only once per press.

Decomposition:
- Shared package stopwatch_pkg:
  - FSM state typedef key_state_t {RELEASED, PRESSED, HELD}.
  - Default timing constants (CLK_HZ = 50000000, DEBOUNCE_20MS, LONG_1S, REPEAT_200MS), also used by the stopwatch for its own tick.
- One natural sub-module: sync_2ff, a reusable 2-flop synchroniser with reset value parameter. It is also used for any other asynchronous board input.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8):
- Reset: hold reset_1_time=0 with key_n=0 -> all outputs 0. Release reset while key stays 0 -> key_level rises 6 edges later with one press_pulse; toggle_state=1.
- Bounce: key_n low 3 cycles, high 1, low 3, high -> key_level, press_pulse, toggle_state remain 0 throughout.
- Clean press/release: key_n low 10 cycles then high -> key_level high on edge 6, press_pulse 1 cycle there. After release, key_level falls 6 edges later with one release_pulse. No long_pulse.
- Long press without KEY_REPEAT_EN: hold 60 cycles -> long_pulse exactly once, 20 cycles after key_level rise. Only one press_pulse. toggle_state flips once.
- Long press with KEY_REPEAT_EN: hold 60 cycles -> long_pulse, then press_pulse every 8 cycles. toggle_state unchanged by repeats. Release gives release_pulse; no repeat pulse on the release edge.
- Async reset mid-HELD: assert reset_1_time for 1 cycle -> outputs 0 immediately, FSM RELEASED, toggle_state 0.
